// File: rtl/conv_seq_ctrl_pkg.sv
// Shared types and width helpers for the convolution sequencer and filter pipeline.
// Sizes are derived from the image geometry so every user agrees on them.
package conv_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } seq_state_e;

  localparam int DEF_IMG_W    = 64;
  localparam int DEF_IMG_H    = 64;
  localparam int DEF_PIPE_LAT = 6;

  // Raster address width for a w x h frame.
  function automatic int addr_width(input int w, input int h);
    return (w * h > 1) ? $clog2(w * h) : 1;
  endfunction

  // Width of a single coordinate counter ranging 0..n-1.
  function automatic int coord_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_seq_ctrl_tag_delay.sv
// Token delay line: a valid bit plus payload shifted one stage per enabled cycle.
// 'occupied' reports whether any stage still carries a valid token.
module tag_delay #(
  parameter int DEPTH = 7,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             occupied
);

  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else if (en) begin
      vld_q[0]  <= in_valid;
      data_q[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i]  <= vld_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign occupied  = |vld_q;

endmodule

// File: rtl/conv_seq_ctrl.sv
// Raster-scan sequencer for a 3x3 convolution: issues pixel reads, tags complete
// windows with their centre and tracks them through the fixed-latency datapath.
module conv_seq_ctrl
  import conv_seq_ctrl_pkg::*;
#(
  parameter  int IMG_W    = DEF_IMG_W,
  parameter  int IMG_H    = DEF_IMG_H,
  parameter  int PIPE_LAT = DEF_PIPE_LAT,
  localparam int AW       = addr_width(IMG_W, IMG_H),
  localparam int XW       = coord_width(IMG_W),
  localparam int YW       = coord_width(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stall,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          pipe_en,
  output logic          out_valid,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic          busy,
  output logic          done
);

  localparam int DEPTH = 1 + PIPE_LAT;
  localparam int PW    = XW + YW;

  seq_state_e    state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [AW-1:0] addr_q, addr_d;

  logic          tok_valid;
  logic [PW-1:0] tok_data;
  logic          tail_valid;
  logic [PW-1:0] tail_data;
  logic          line_occupied;
  logic          last_pix;

  assign last_pix = (x_q == XW'(IMG_W - 1)) && (y_q == YW'(IMG_H - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
    end
  end

  // Nothing advances while stalled, so every branch below assumes stall is low.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    addr_d    = addr_q;
    rd_en     = 1'b0;
    done      = 1'b0;
    tok_valid = 1'b0;
    tok_data  = '0;
    if (!stall) begin
      unique case (state_q)
        IDLE: begin
          if (start) state_d = READ;
        end
        READ: begin
          rd_en = 1'b1;
          if ((x_q >= XW'(2)) && (y_q >= YW'(2))) begin
            tok_valid = 1'b1;
            tok_data  = {x_q - XW'(1), y_q - YW'(1)};
          end
          if (last_pix) begin
            x_d     = '0;
            y_d     = '0;
            addr_d  = '0;
            state_d = DRAIN;
          end else begin
            addr_d = addr_q + AW'(1);
            if (x_q == XW'(IMG_W - 1)) begin
              x_d = '0;
              y_d = y_q + YW'(1);
            end else begin
              x_d = x_q + XW'(1);
            end
          end
        end
        DRAIN: begin
          if (!line_occupied) state_d = FIN;
        end
        FIN: begin
          done    = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // One extra stage beyond PIPE_LAT covers the pixel memory read latency.
  tag_delay #(
    .DEPTH (DEPTH),
    .WIDTH (PW)
  ) u_tag_delay (
    .clk       (clk),
    .rst       (rst),
    .en        (!stall),
    .in_valid  (tok_valid),
    .in_data   (tok_data),
    .out_valid (tail_valid),
    .out_data  (tail_data),
    .occupied  (line_occupied)
  );

  assign rd_addr   = addr_q;
  assign pipe_en   = !stall;
  assign out_valid = tail_valid && !stall;
  assign out_x     = tail_data[PW-1:YW];
  assign out_y     = tail_data[YW-1:0];
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Self-checking bench for conv_seq_ctrl: directed scenarios plus random start/stall/reset
// traffic, compared each cycle against a schedule model counted in unstalled cycles.
module tb_conv_seq_ctrl;

   localparam int W = 4;
   localparam int H = 4;
   localparam int L = 6;
   localparam int N = W * H;

   logic       clk = 1'b0;
   logic       rst, start, stall;
   logic       rdEn, pipeEn, outValid, busy, done;
   logic [3:0] rdAddr;
   logic [1:0] outX, outY;

   logic       rstB, startB, stallB;
   logic       rdEnB, pipeEnB, outValidB, busyB, doneB;
   logic [3:0] rdAddrB;
   logic [1:0] outXB, outYB;

   int nChecks = 0;
   int nFails  = 0;

   // Reference model: whether a frame is in flight and how many unstalled cycles it has run.
   bit mActive = 1'b0;
   int mPos    = 0;

   always #5 clk = ~clk;

   conv_seq_ctrl #(.IMG_W(W), .IMG_H(H), .PIPE_LAT(L)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stall     (stall),
      .rd_en     (rdEn),
      .rd_addr   (rdAddr),
      .pipe_en   (pipeEn),
      .out_valid (outValid),
      .out_x     (outX),
      .out_y     (outY),
      .busy      (busy),
      .done      (done)
   );

   conv_seq_ctrl #(.IMG_W(3), .IMG_H(3), .PIPE_LAT(L)) dutSmall (
      .clk       (clk),
      .rst       (rstB),
      .start     (startB),
      .stall     (stallB),
      .rd_en     (rdEnB),
      .rd_addr   (rdAddrB),
      .pipe_en   (pipeEnB),
      .out_valid (outValidB),
      .out_x     (outXB),
      .out_y     (outYB),
      .busy      (busyB),
      .done      (doneB)
   );

   // Every comparison in the bench funnels through here so the counts stay honest.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
      end
   endtask

   // Drives one cycle of inputs, checks outputs mid-cycle against the model,
   // then advances the model across the clock edge.
   task automatic applyStimulus(input logic s, input logic st, input logic r);
      int eRd, eAddr, eOv, eOx, eOy, eBusy, eDone, rIdx;
      start = s;
      stall = st;
      rst   = r;
      eRd = 0; eAddr = 0; eOv = 0; eOx = 0; eOy = 0; eDone = 0;
      eBusy = mActive ? 1 : 0;
      if (mActive) begin
         if (mPos < N) eAddr = mPos;
         if (!st) begin
            eRd  = (mPos < N) ? 1 : 0;
            rIdx = mPos - 1 - L;
            if (rIdx >= 0 && rIdx < N && (rIdx % W) >= 2 && (rIdx / W) >= 2) begin
               eOv = 1;
               eOx = (rIdx % W) - 1;
               eOy = (rIdx / W) - 1;
            end
            eDone = (mPos == N + L + 2) ? 1 : 0;
         end
      end
      @(negedge clk);
      checkOutput("rd_en", rdEn, eRd);
      checkOutput("rd_addr", rdAddr, eAddr);
      checkOutput("pipe_en", pipeEn, st ? 0 : 1);
      checkOutput("out_valid", outValid, eOv);
      checkOutput("busy", busy, eBusy);
      checkOutput("done", done, eDone);
      if (eOv != 0) begin
         checkOutput("out_x", outX, eOx);
         checkOutput("out_y", outY, eOy);
      end
      @(posedge clk);
      if (r) begin
         mActive = 1'b0;
         mPos    = 0;
      end else if (!st) begin
         if (!mActive) begin
            if (s) begin
               mActive = 1'b1;
               mPos    = 0;
            end
         end else begin
            mPos++;
            if (mPos > N + L + 2) mActive = 1'b0;
         end
      end
      #1;
   endtask

   initial begin
      int pulsesB, donesB, pulsesAtDone;
      rst = 1'b1; start = 1'b0; stall = 1'b0;
      rstB = 1'b1; startB = 1'b0; stallB = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      applyStimulus(1'b0, 1'b0, 1'b1);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);

      // Plain frame with a redundant start presented mid-READ.
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 30; c++) applyStimulus(c == 5, 1'b0, 1'b0);

      // Stall for three cycles right after address 5 has been read.
      applyStimulus(1'b1, 1'b0, 1'b0);
      repeat (6) applyStimulus(1'b0, 1'b0, 1'b0);
      repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
      repeat (30) applyStimulus(1'b0, 1'b0, 1'b0);

      // Start blocked by stall, then re-presented; reset lands in DRAIN.
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      repeat (18) applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      repeat (30) applyStimulus(1'b0, 1'b0, 1'b0);

      // Random traffic with occasional resets.
      for (int c = 0; c < 800; c++) begin
         applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                       $urandom_range(0, 199) == 0);
      end
      repeat (30) applyStimulus(1'b0, 1'b0, 1'b0);

      // Minimal 3x3 frame: exactly one result centred at (1,1), then done.
      rstB = 1'b0;
      startB = 1'b1;
      @(posedge clk);
      #1;
      startB = 1'b0;
      pulsesB = 0;
      donesB = 0;
      pulsesAtDone = -1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (outValidB) begin
            pulsesB++;
            checkOutput("small out_x", outXB, 1);
            checkOutput("small out_y", outYB, 1);
         end
         if (doneB) begin
            donesB++;
            pulsesAtDone = pulsesB;
         end
         @(posedge clk);
         #1;
      end
      checkOutput("small pulse count", pulsesB, 1);
      checkOutput("small done count", donesB, 1);
      checkOutput("small pulses before done", pulsesAtDone, 1);
      @(negedge clk);
      checkOutput("small busy after frame", busyB, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
